// File: rtl/vrf_read_dispatch.sv
// vrf_read_dispatch
//   Round-robin dispatcher that maps up to VRF_RPORT_NUM of REQ_NUM pending
//   vector-operand read requests onto the read ports of the vector register
//   file. Reads that target a register being written in the same cycle are
//   deferred (RAW guard). A registered read packet is held while the regfile
//   reports busy.
//
// Optional feature: define VRF_RD_STALL_CNT_EN to add the stall_cnt output.
//
// Ports
//   clk, rstn        clock, synchronous active-low reset
//   req_vld          per-requester read pending
//   req_vaddr        per-requester vector register address
//   req_rs_idx       per-requester reservation-station tag
//   req_field_idx    per-requester operand field tag
//   req_rdy          per-requester grant (combinational)
//   wr0_vld, waddr0  regfile write port 0
//   wr1_vld, waddr1  regfile write port 1
//   busy             regfile cannot accept a new packet
//   rd_vld           per-port read valid (registered)
//   rd_vaddr         per-port register address
//   rd_rs_idx        per-port reservation-station tag
//   rd_field_idx     per-port operand field tag
//   stall_cnt        cycles stalled with a live packet (VRF_RD_STALL_CNT_EN only)

module vrf_read_dispatch #(
   parameter int unsigned REQ_NUM         = 8,
   parameter int unsigned VRF_RPORT_NUM   = 5,
   parameter int unsigned VREG_ADDR_WIDTH = 5,
   parameter int unsigned RS_IDX_W        = 4,
   parameter int unsigned FIELD_W         = 2
) (
   input  logic                                   clk,
   input  logic                                   rstn,
   input  logic [REQ_NUM-1:0]                     req_vld,
   input  logic [REQ_NUM*VREG_ADDR_WIDTH-1:0]     req_vaddr,
   input  logic [REQ_NUM*RS_IDX_W-1:0]            req_rs_idx,
   input  logic [REQ_NUM*FIELD_W-1:0]             req_field_idx,
   output logic [REQ_NUM-1:0]                     req_rdy,
   input  logic                                   wr0_vld,
   input  logic                                   wr1_vld,
   input  logic [VREG_ADDR_WIDTH-1:0]             waddr0,
   input  logic [VREG_ADDR_WIDTH-1:0]             waddr1,
   input  logic                                   busy,
   output logic [VRF_RPORT_NUM-1:0]               rd_vld,
   output logic [VRF_RPORT_NUM*VREG_ADDR_WIDTH-1:0] rd_vaddr,
   output logic [VRF_RPORT_NUM*RS_IDX_W-1:0]      rd_rs_idx,
   output logic [VRF_RPORT_NUM*FIELD_W-1:0]       rd_field_idx
`ifdef VRF_RD_STALL_CNT_EN
   ,
   output logic [31:0]                            stall_cnt
`endif
);

   localparam int unsigned PtrW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

   logic [PtrW-1:0]                          rr_ptr_q, rr_ptr_d;
   logic [REQ_NUM-1:0]                       eligible;
   logic [REQ_NUM-1:0]                       grant;
   logic [VRF_RPORT_NUM-1:0]                 pk_vld;
   logic [VRF_RPORT_NUM*VREG_ADDR_WIDTH-1:0] pk_vaddr;
   logic [VRF_RPORT_NUM*RS_IDX_W-1:0]        pk_rs_idx;
   logic [VRF_RPORT_NUM*FIELD_W-1:0]         pk_field_idx;

   // A request is deferred when either write port targets the same register.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         eligible[i] = req_vld[i]
                     & ~(wr0_vld & (waddr0 == req_vaddr[i*VREG_ADDR_WIDTH +: VREG_ADDR_WIDTH]))
                     & ~(wr1_vld & (waddr1 == req_vaddr[i*VREG_ADDR_WIDTH +: VREG_ADDR_WIDTH]));
      end
   end

   // Scan from rr_ptr_q, wrapping; the k-th eligible requester lands on port k.
   always_comb begin
      int unsigned idx;
      int unsigned cnt;
      grant        = '0;
      pk_vld       = '0;
      pk_vaddr     = '0;
      pk_rs_idx    = '0;
      pk_field_idx = '0;
      rr_ptr_d     = rr_ptr_q;
      cnt          = 0;
      idx          = 0;
      if (!busy) begin
         for (int unsigned k = 0; k < REQ_NUM; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= REQ_NUM) begin
               idx = idx - REQ_NUM;
            end
            if (eligible[idx] && (cnt < VRF_RPORT_NUM)) begin
               grant[idx]  = 1'b1;
               pk_vld[cnt] = 1'b1;
               pk_vaddr[cnt*VREG_ADDR_WIDTH +: VREG_ADDR_WIDTH] =
                  req_vaddr[idx*VREG_ADDR_WIDTH +: VREG_ADDR_WIDTH];
               pk_rs_idx[cnt*RS_IDX_W +: RS_IDX_W] = req_rs_idx[idx*RS_IDX_W +: RS_IDX_W];
               pk_field_idx[cnt*FIELD_W +: FIELD_W] = req_field_idx[idx*FIELD_W +: FIELD_W];
               rr_ptr_d = (idx + 1 >= REQ_NUM) ? '0 : PtrW'(idx + 1);
               cnt      = cnt + 1;
            end
         end
      end
   end

   // No grants may be advertised while reset is asserted.
   assign req_rdy = grant & {REQ_NUM{rstn}};

   // While busy the packet and pointer hold so the regfile sees it again.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_vld       <= '0;
         rd_vaddr     <= '0;
         rd_rs_idx    <= '0;
         rd_field_idx <= '0;
         rr_ptr_q     <= '0;
      end else if (!busy) begin
         rd_vld       <= pk_vld;
         rd_vaddr     <= pk_vaddr;
         rd_rs_idx    <= pk_rs_idx;
         rd_field_idx <= pk_field_idx;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

`ifdef VRF_RD_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (!rstn) begin
         stall_cnt <= '0;
      end else if (busy && (|rd_vld) && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`else
   // Stall counter not built.
`endif

endmodule

// File: tb/tb_vrf_read_dispatch.sv
module tb_vrf_read_dispatch;

   logic        clk;
   logic        rstn;
   logic [7:0]  req_vld;
   logic [39:0] req_vaddr;
   logic [31:0] req_rs_idx;
   logic [15:0] req_field_idx;
   logic [7:0]  req_rdy;
   logic        wr0_vld, wr1_vld;
   logic [4:0]  waddr0, waddr1;
   logic        busy;
   logic [4:0]  rd_vld;
   logic [24:0] rd_vaddr;
   logic [19:0] rd_rs_idx;
   logic [9:0]  rd_field_idx;
`ifdef VRF_RD_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int errors = 0;
   int checks = 0;
   logic [24:0] held_vaddr;

   vrf_read_dispatch dut (
      .clk           (clk),
      .rstn          (rstn),
      .req_vld       (req_vld),
      .req_vaddr     (req_vaddr),
      .req_rs_idx    (req_rs_idx),
      .req_field_idx (req_field_idx),
      .req_rdy       (req_rdy),
      .wr0_vld       (wr0_vld),
      .wr1_vld       (wr1_vld),
      .waddr0        (waddr0),
      .waddr1        (waddr1),
      .busy          (busy),
      .rd_vld        (rd_vld),
      .rd_vaddr      (rd_vaddr),
      .rd_rs_idx     (rd_rs_idx),
      .rd_field_idx  (rd_field_idx)
`ifdef VRF_RD_STALL_CNT_EN
      ,
      .stall_cnt     (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vaddr(input int i, input logic [4:0] v);
      req_vaddr[i*5 +: 5] = v;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (req_rdy !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdy cyc%0d: got %h want 00", c, req_rdy);
         end
         tick();
         checks++;
         if (rd_vld !== 5'b00000) begin
            errors++;
            $display("FAIL reset_rd_vld cyc%0d: got %b want 00000", c, rd_vld);
         end
      end
      rstn = 1'b1;
      #1;
      checks++;
      if (req_rdy !== 8'h1F) begin
         errors++;
         $display("FAIL rr_c1_rdy: got %h want 1f", req_rdy);
      end
      tick();
      checks++;
      if (rd_vld !== 5'b11111) begin
         errors++;
         $display("FAIL rr_c1_vld: got %b want 11111", rd_vld);
      end
      checks++;
      if (rd_rs_idx !== 20'h43210) begin
         errors++;
         $display("FAIL rr_c1_rs: got %h want 43210", rd_rs_idx);
      end
      checks++;
      if (rd_field_idx !== 10'h0E4) begin
         errors++;
         $display("FAIL rr_c1_field: got %h want 0e4", rd_field_idx);
      end
   endtask

   task automatic test_round_robin();
      #1;
      checks++;
      if (req_rdy !== 8'hE3) begin
         errors++;
         $display("FAIL rr_c2_rdy: got %h want e3", req_rdy);
      end
      tick();
      checks++;
      if (rd_rs_idx !== 20'h10765) begin
         errors++;
         $display("FAIL rr_c2_rs: got %h want 10765", rd_rs_idx);
      end
   endtask

   task automatic test_sparse();
      // rr_ptr is 2: a lone grant of req 2 moves it to 3
      req_vld = 8'h04;
      #1;
      checks++;
      if (req_rdy !== 8'h04) begin
         errors++;
         $display("FAIL single_rdy: got %h want 04", req_rdy);
      end
      tick();
      checks++;
      if (rd_vld !== 5'b00001 || rd_rs_idx[3:0] !== 4'd2) begin
         errors++;
         $display("FAIL single_rd: got vld=%b rs=%h want vld=00001 rs=2", rd_vld, rd_rs_idx[3:0]);
      end
      req_vld = 8'b1000_0010;
      #1;
      checks++;
      if (req_rdy !== 8'h82) begin
         errors++;
         $display("FAIL sparse_rdy: got %h want 82", req_rdy);
      end
      tick();
      checks++;
      if (rd_vld !== 5'b00011 || rd_rs_idx[7:0] !== 8'h17) begin
         errors++;
         $display("FAIL sparse_rd: got vld=%b rs=%h want vld=00011 rs=17", rd_vld, rd_rs_idx[7:0]);
      end
      req_vld = 8'h00;
      #1;
      checks++;
      if (req_rdy !== 8'h00) begin
         errors++;
         $display("FAIL idle_rdy: got %h want 00", req_rdy);
      end
      tick();
      checks++;
      if (rd_vld !== 5'b00000) begin
         errors++;
         $display("FAIL idle_rd_vld: got %b want 00000", rd_vld);
      end
   endtask

   task automatic test_stall();
      // rr_ptr is 2: requesters 2..6 carry vaddr 1,3,5,7,9
      set_vaddr(2, 5'd1);
      set_vaddr(3, 5'd3);
      set_vaddr(4, 5'd5);
      set_vaddr(5, 5'd7);
      set_vaddr(6, 5'd9);
      held_vaddr = {5'd9, 5'd7, 5'd5, 5'd3, 5'd1};
      req_vld = 8'hFF;
      #1;
      checks++;
      if (req_rdy !== 8'h7C) begin
         errors++;
         $display("FAIL stall_pre_rdy: got %h want 7c", req_rdy);
      end
      tick();
      checks++;
      if (rd_vld !== 5'b11111 || rd_vaddr !== held_vaddr) begin
         errors++;
         $display("FAIL stall_pkt: got vld=%b va=%h want vld=11111 va=%h", rd_vld, rd_vaddr,
                  held_vaddr);
      end
      busy = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (req_rdy !== 8'h00) begin
            errors++;
            $display("FAIL stall_rdy cyc%0d: got %h want 00", c, req_rdy);
         end
         tick();
         checks++;
         if (rd_vld !== 5'b11111 || rd_vaddr !== held_vaddr || rd_rs_idx !== 20'h65432) begin
            errors++;
            $display("FAIL stall_hold cyc%0d: got vld=%b va=%h rs=%h", c, rd_vld, rd_vaddr,
                     rd_rs_idx);
         end
      end
      busy = 1'b0;
      #1;
      checks++;
      if (req_rdy !== 8'h8F) begin
         errors++;
         $display("FAIL stall_post_rdy: got %h want 8f", req_rdy);
      end
      tick();
      checks++;
      if (rd_rs_idx !== 20'h32107) begin
         errors++;
         $display("FAIL stall_post_rs: got %h want 32107", rd_rs_idx);
      end
`ifdef VRF_RD_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 32'd4) begin
         errors++;
         $display("FAIL stall_cnt: got %0d want 4", stall_cnt);
      end
`endif
   endtask

   task automatic test_raw();
      // rr_ptr is 4
      set_vaddr(0, 5'd6);
      req_vld = 8'h01;
      wr1_vld = 1'b1;
      waddr1  = 5'd6;
      #1;
      checks++;
      if (req_rdy !== 8'h00) begin
         errors++;
         $display("FAIL raw_wr1_rdy: got %h want 00", req_rdy);
      end
      tick();
      checks++;
      if (rd_vld !== 5'b00000) begin
         errors++;
         $display("FAIL raw_wr1_vld: got %b want 00000", rd_vld);
      end
      wr1_vld = 1'b0;
      wr0_vld = 1'b1;
      waddr0  = 5'd7;
      #1;
      checks++;
      if (req_rdy !== 8'h01) begin
         errors++;
         $display("FAIL raw_clear_rdy: got %h want 01", req_rdy);
      end
      tick();
      checks++;
      if (rd_vld !== 5'b00001 || rd_vaddr[4:0] !== 5'd6) begin
         errors++;
         $display("FAIL raw_clear_rd: got vld=%b va=%0d want vld=00001 va=6", rd_vld,
                  rd_vaddr[4:0]);
      end
      waddr0 = 5'd6;
      #1;
      checks++;
      if (req_rdy !== 8'h00) begin
         errors++;
         $display("FAIL raw_wr0_rdy: got %h want 00", req_rdy);
      end
      tick();
      wr0_vld = 1'b0;
   endtask

   task automatic test_duplicate();
      // rr_ptr is 1
      set_vaddr(1, 5'd12);
      set_vaddr(2, 5'd12);
      req_vld = 8'h06;
      #1;
      checks++;
      if (req_rdy !== 8'h06) begin
         errors++;
         $display("FAIL dup_rdy: got %h want 06", req_rdy);
      end
      tick();
      checks++;
      if (rd_vld !== 5'b00011 || rd_vaddr[9:0] !== {5'd12, 5'd12} || rd_rs_idx[7:0] !== 8'h21)
      begin
         errors++;
         $display("FAIL dup_rd: got vld=%b va=%h rs=%h want vld=00011 va=18c rs=21", rd_vld,
                  rd_vaddr[9:0], rd_rs_idx[7:0]);
      end
   endtask

   task automatic test_reset_mid_stall();
      // rr_ptr is 3
      req_vld = 8'hFF;
      #1;
      checks++;
      if (req_rdy !== 8'hF8) begin
         errors++;
         $display("FAIL ms_rdy: got %h want f8", req_rdy);
      end
      tick();
      busy = 1'b1;
      tick();
      checks++;
      if (rd_vld !== 5'b11111) begin
         errors++;
         $display("FAIL ms_held: got %b want 11111", rd_vld);
      end
      rstn = 1'b0;
      tick();
      checks++;
      if (rd_vld !== 5'b00000 || rd_vaddr !== 25'd0 || rd_rs_idx !== 20'd0) begin
         errors++;
         $display("FAIL ms_cleared: got vld=%b va=%h rs=%h want all 0", rd_vld, rd_vaddr,
                  rd_rs_idx);
      end
`ifdef VRF_RD_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 32'd0) begin
         errors++;
         $display("FAIL ms_stall_cnt: got %0d want 0", stall_cnt);
      end
`endif
      rstn = 1'b1;
      busy = 1'b0;
      #1;
      checks++;
      if (req_rdy !== 8'h1F) begin
         errors++;
         $display("FAIL ms_after_rdy: got %h want 1f", req_rdy);
      end
      tick();
      checks++;
      if (rd_rs_idx !== 20'h43210) begin
         errors++;
         $display("FAIL ms_after_rs: got %h want 43210", rd_rs_idx);
      end
   endtask

   initial begin
      rstn    = 1'b0;
      busy    = 1'b0;
      wr0_vld = 1'b0;
      wr1_vld = 1'b0;
      waddr0  = 5'd0;
      waddr1  = 5'd0;
      req_vld = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         req_vaddr[i*5 +: 5]     = 5'(i + 16);
         req_rs_idx[i*4 +: 4]    = 4'(i);
         req_field_idx[i*2 +: 2] = 2'(i);
      end
      test_reset();
      test_round_robin();
      test_sparse();
      test_stall();
      test_raw();
      test_duplicate();
      test_reset_mid_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
